// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/status controller.
// Holds default geometry and threshold values plus the pointer type.
package fifo_pkg;

   localparam int unsigned FIFO_DEPTH    = 16;
   localparam int unsigned FIFO_PTR_W    = 5;
   localparam int unsigned FIFO_AF_LEVEL = 14;
   localparam int unsigned FIFO_AE_LEVEL = 2;

   // Pointer: low bits address the array, MSB is the lap (wrap) bit.
   typedef logic [FIFO_PTR_W-1:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer register with increment enable.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, clears the pointer
//   inc   - advance the pointer by one at the next edge
//   ptr   - registered pointer, rolls over modulo 2**PTR_W
module fifo_ptr_cnt
   import fifo_pkg::*;
#(
   parameter int unsigned PTR_W = FIFO_PTR_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // Natural binary rollover carries into the wrap bit every lap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + PTR_W'(1);
      end
   end

endmodule : fifo_ptr_cnt

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and status controller for a first-word-fall-through FIFO array.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   wr_en, rd_en        - producer write / consumer read requests
//   fifo_we             - array write strobe (combinational, accepted write)
//   wptr, rptr          - registered write/read pointers (MSB = wrap bit)
//   fifo_full/empty     - occupancy DEPTH / zero
//   fifo_almost_full    - fill_level >= AF_LEVEL
//   fifo_almost_empty   - fill_level <= AE_LEVEL
//   fill_level          - current occupancy, 0..DEPTH
//   fifo_overflow       - registered pulse, a write was rejected
//   fifo_underflow      - registered pulse, a read was rejected
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH    = FIFO_DEPTH,
   parameter int unsigned PTR_W    = FIFO_PTR_W,
   parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
   parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic             fifo_we,
   output logic [PTR_W-1:0] wptr,
   output logic [PTR_W-1:0] rptr,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             fifo_almost_full,
   output logic             fifo_almost_empty,
   output logic [PTR_W-1:0] fill_level,
   output logic             fifo_overflow,
   output logic             fifo_underflow
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic wr_acc;
   logic rd_acc;

   // Acceptance uses registered flags only, so a full FIFO still takes a read
   // and an empty FIFO still takes a write in the same cycle.
   always_comb begin
      wr_acc  = wr_en & ~fifo_full;
      rd_acc  = rd_en & ~fifo_empty;
      fifo_we = wr_acc;
   end

   fifo_ptr_cnt #(.PTR_W(PTR_W)) u_wr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_acc),
      .ptr   (wptr)
   );

   fifo_ptr_cnt #(.PTR_W(PTR_W)) u_rd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_acc),
      .ptr   (rptr)
   );

   // Status decode from the registered pointers; equal addresses are full
   // when the pointers are on different laps, empty when on the same lap.
   always_comb begin
      fifo_empty        = (wptr == rptr);
      fifo_full         = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
      fill_level        = wptr - rptr;
      fifo_almost_full  = (fill_level >= PTR_W'(AF_LEVEL));
      fifo_almost_empty = (fill_level <= PTR_W'(AE_LEVEL));
   end

   // One pulse per offending request cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_overflow  <= 1'b0;
         fifo_underflow <= 1'b0;
      end else begin
         fifo_overflow  <= wr_en & fifo_full;
         fifo_underflow <= rd_en & fifo_empty;
      end
   end

endmodule : fifo_ptr_ctrl

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl with an array model and data scoreboard.
module tb_fifo_ptr_ctrl;
   import fifo_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       fifo_we;
   ptr_t       wptr;
   ptr_t       rptr;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_almost_full;
   logic       fifo_almost_empty;
   ptr_t       fill_level;
   logic       fifo_overflow;
   logic       fifo_underflow;

   logic [7:0] data_in = 8'h00;
   logic [7:0] mem [16];

   int         n_checks = 0;
   int         n_fail   = 0;

   // Reference: contents as a queue, plus running totals of accepted ops.
   logic [7:0] q [$];
   int         wr_total = 0;
   int         rd_total = 0;
   logic       exp_ovf  = 1'b0;
   logic       exp_udf  = 1'b0;

   always #5 clk = ~clk;

   fifo_ptr_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .wr_en             (wr_en),
      .rd_en             (rd_en),
      .fifo_we           (fifo_we),
      .wptr              (wptr),
      .rptr              (rptr),
      .fifo_full         (fifo_full),
      .fifo_empty        (fifo_empty),
      .fifo_almost_full  (fifo_almost_full),
      .fifo_almost_empty (fifo_almost_empty),
      .fill_level        (fill_level),
      .fifo_overflow     (fifo_overflow),
      .fifo_underflow    (fifo_underflow)
   );

   // Memory array the controller drives; read side is FWFT at rptr.
   always @(posedge clk) begin
      if (fifo_we) mem[wptr[3:0]] <= data_in;
   end

   task automatic model_reset();
      q.delete();
      wr_total = 0;
      rd_total = 0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
   endtask

   task automatic drive(input logic w, input logic r);
      wr_en   = w;
      rd_en   = r;
      data_in = 8'($urandom);
   endtask

   // Advance one clock, updating the model from the FIFO's rules.
   task automatic tick();
      bit wacc;
      bit racc;
      wacc    = wr_en && (q.size() < 16);
      racc    = rd_en && (q.size() > 0);
      exp_ovf = wr_en && (q.size() == 16);
      exp_udf = rd_en && (q.size() == 0);
      @(posedge clk);
      if (racc) begin void'(q.pop_front()); rd_total++; end
      if (wacc) begin q.push_back(data_in); wr_total++; end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (wptr !== 5'd0) begin n_fail++; $display("FAIL rst_wptr: got %0d expected 0", wptr); end
      n_checks++; if (rptr !== 5'd0) begin n_fail++; $display("FAIL rst_rptr: got %0d expected 0", rptr); end
      n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL rst_fill: got %0d expected 0", fill_level); end
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", fifo_empty); end
      n_checks++; if (fifo_almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_ae: got %b expected 1", fifo_almost_empty); end
      n_checks++; if ({fifo_full, fifo_almost_full, fifo_overflow, fifo_underflow, fifo_we} !== 5'b0)
         begin n_fail++; $display("FAIL rst_flags: got %b expected 00000",
            {fifo_full, fifo_almost_full, fifo_overflow, fifo_underflow, fifo_we}); end
      rst_n = 1'b1;
      repeat (3) begin drive(1'b0, 1'b0); tick(); end
      n_checks++; if ({wptr, rptr, fill_level} !== 15'd0) begin n_fail++; $display("FAIL idle_ptrs: got %h expected 0", {wptr, rptr, fill_level}); end
      n_checks++; if (fifo_empty !== 1'b1 || fifo_we !== 1'b0) begin n_fail++; $display("FAIL idle_flags: empty=%b we=%b expected 1 0", fifo_empty, fifo_we); end
   endtask

   task automatic test_fill_full();
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 1'b0);
         #1;
         n_checks++; if (fifo_we !== 1'b1) begin n_fail++; $display("FAIL fill_we[%0d]: got %b expected 1", i, fifo_we); end
         tick();
         n_checks++; if (fill_level !== 5'(i)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, fill_level, i); end
         n_checks++; if (fifo_almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, fifo_almost_full, (i >= 14)); end
         n_checks++; if (fifo_full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, fifo_full, (i == 16)); end
      end
      n_checks++; if (wptr !== 5'b10000) begin n_fail++; $display("FAIL full_wptr: got %b expected 10000", wptr); end
      drive(1'b1, 1'b0);
      #1;
      n_checks++; if (fifo_we !== 1'b0) begin n_fail++; $display("FAIL ovf_we: got %b expected 0", fifo_we); end
      tick();
      n_checks++; if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", fifo_overflow); end
      n_checks++; if (wptr !== 5'b10000 || fill_level !== 5'd16) begin n_fail++; $display("FAIL ovf_hold: wptr=%b fill=%0d expected 10000 16", wptr, fill_level); end
      drive(1'b0, 1'b0);
      tick();
      n_checks++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_single: got %b expected 0", fifo_overflow); end
   endtask

   task automatic test_drain_empty();
      for (int i = 1; i <= 16; i++) begin
         n_checks++; if (mem[rptr[3:0]] !== q[0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, mem[rptr[3:0]], q[0]); end
         drive(1'b0, 1'b1);
         tick();
         n_checks++; if (fill_level !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_level[%0d]: got %0d expected %0d", i, fill_level, 16 - i); end
         n_checks++; if (fifo_almost_empty !== ((16 - i) <= 2)) begin n_fail++; $display("FAIL drain_ae[%0d]: got %b expected %b", i, fifo_almost_empty, ((16 - i) <= 2)); end
      end
      n_checks++; if (rptr !== 5'b10000 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_end: rptr=%b empty=%b expected 10000 1", rptr, fifo_empty); end
      drive(1'b0, 1'b1);
      tick();
      n_checks++; if (fifo_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse: got %b expected 1", fifo_underflow); end
      n_checks++; if (rptr !== 5'b10000) begin n_fail++; $display("FAIL udf_hold: rptr=%b expected 10000", rptr); end
      drive(1'b0, 1'b0);
      tick();
      n_checks++; if (fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL udf_single: got %b expected 0", fifo_underflow); end
   endtask

   task automatic test_wrap();
      bit   saw_w = 0;
      bit   saw_r = 0;
      ptr_t pw;
      ptr_t pr;
      repeat (5) begin drive(1'b1, 1'b0); tick(); end
      for (int i = 0; i < 40; i++) begin
         n_checks++; if (mem[rptr[3:0]] !== q[0]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, mem[rptr[3:0]], q[0]); end
         pw = wptr;
         pr = rptr;
         drive(1'b1, 1'b1);
         tick();
         if (wptr < pw) saw_w = 1;
         if (rptr < pr) saw_r = 1;
         n_checks++; if (fill_level !== 5'd5) begin n_fail++; $display("FAIL wrap_level[%0d]: got %0d expected 5", i, fill_level); end
      end
      n_checks++; if (saw_w !== 1'b1 || saw_r !== 1'b1) begin n_fail++; $display("FAIL wrap_seen: w=%b r=%b expected 1 1", saw_w, saw_r); end
      n_checks++; if (wptr !== ptr_t'(wr_total) || rptr !== ptr_t'(rd_total)) begin n_fail++;
         $display("FAIL wrap_ptrs: wptr=%0d rptr=%0d expected %0d %0d", wptr, rptr, ptr_t'(wr_total), ptr_t'(rd_total)); end
   endtask

   task automatic test_simul_boundaries();
      while (q.size() > 0) begin drive(1'b0, 1'b1); tick(); end
      drive(1'b1, 1'b1);
      #1;
      n_checks++; if (fifo_we !== 1'b1) begin n_fail++; $display("FAIL sim_empty_we: got %b expected 1", fifo_we); end
      tick();
      n_checks++; if (fifo_underflow !== 1'b1 || fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL sim_empty_err: udf=%b ovf=%b expected 1 0", fifo_underflow, fifo_overflow); end
      n_checks++; if (fill_level !== 5'd1) begin n_fail++; $display("FAIL sim_empty_level: got %0d expected 1", fill_level); end
      while (q.size() < 16) begin drive(1'b1, 1'b0); tick(); end
      drive(1'b1, 1'b1);
      #1;
      n_checks++; if (fifo_we !== 1'b0) begin n_fail++; $display("FAIL sim_full_we: got %b expected 0", fifo_we); end
      tick();
      n_checks++; if (fifo_overflow !== 1'b1 || fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL sim_full_err: ovf=%b udf=%b expected 1 0", fifo_overflow, fifo_underflow); end
      n_checks++; if (fill_level !== 5'd15) begin n_fail++; $display("FAIL sim_full_level: got %0d expected 15", fill_level); end
   endtask

   task automatic test_random();
      int   bias;
      logic w;
      logic r;
      for (int i = 0; i < 400; i++) begin
         bias = ((i / 50) % 2 == 0) ? 80 : 20;
         w = ($urandom_range(0, 99) < bias);
         r = ($urandom_range(0, 99) < (100 - bias));
         drive(w, r);
         #1;
         n_checks++; if (fifo_we !== (w && q.size() < 16)) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b expected %b", i, fifo_we, (w && q.size() < 16)); end
         tick();
         n_checks++; if (wptr !== ptr_t'(wr_total) || rptr !== ptr_t'(rd_total)) begin n_fail++;
            $display("FAIL rnd_ptrs[%0d]: wptr=%0d rptr=%0d expected %0d %0d", i, wptr, rptr, ptr_t'(wr_total), ptr_t'(rd_total)); end
         n_checks++; if (fill_level !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, fill_level, q.size()); end
         n_checks++; if ({fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty} !==
                         {q.size() == 16, q.size() == 0, q.size() >= 14, q.size() <= 2}) begin n_fail++;
            $display("FAIL rnd_flags[%0d]: got %b expected %b", i, {fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty},
                     {q.size() == 16, q.size() == 0, q.size() >= 14, q.size() <= 2}); end
         n_checks++; if (fifo_overflow !== exp_ovf || fifo_underflow !== exp_udf) begin n_fail++;
            $display("FAIL rnd_err[%0d]: ovf=%b udf=%b expected %b %b", i, fifo_overflow, fifo_underflow, exp_ovf, exp_udf); end
         if (q.size() > 0) begin
            n_checks++; if (mem[rptr[3:0]] !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, mem[rptr[3:0]], q[0]); end
         end
      end
   endtask

   task automatic test_async_reset();
      while (q.size() < 9) begin drive(1'b1, 1'b0); tick(); end
      while (q.size() > 9) begin drive(1'b0, 1'b1); tick(); end
      drive(1'b0, 1'b0);
      n_checks++; if (fill_level !== 5'd9) begin n_fail++; $display("FAIL arst_pre_level: got %0d expected 9", fill_level); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({wptr, rptr, fill_level} !== 15'd0) begin n_fail++; $display("FAIL arst_ptrs: got %h expected 0", {wptr, rptr, fill_level}); end
      n_checks++; if ({fifo_empty, fifo_almost_empty, fifo_full, fifo_almost_full, fifo_overflow, fifo_underflow} !== 6'b110000)
         begin n_fail++; $display("FAIL arst_flags: got %b expected 110000",
            {fifo_empty, fifo_almost_empty, fifo_full, fifo_almost_full, fifo_overflow, fifo_underflow}); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0);
      tick();
      n_checks++; if (fill_level !== 5'd1 || wptr !== 5'd1) begin n_fail++; $display("FAIL arst_resume: fill=%0d wptr=%0d expected 1 1", fill_level, wptr); end
      n_checks++; if (mem[rptr[3:0]] !== q[0]) begin n_fail++; $display("FAIL arst_data: got %h expected %h", mem[rptr[3:0]], q[0]); end
   endtask

   initial begin
      test_reset();
      test_fill_full();
      test_drain_empty();
      test_wrap();
      test_simul_boundaries();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fifo_ptr_ctrl

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Pointer and status controller that sits directly upstream of the 16-entry FIFO memory array. It accepts producer write requests and consumer read requests. It generates the array's write enable, plus the 5-bit write and read pointers (4 address bits and 1 wrap bit). It also produces full, empty, almost-full, almost-empty, fill-level and error flags. Read data is first-word-fall-through: the array shows the entry at rptr combinationally, and a read only advances rptr.

Parameters:
DEPTH, 16, number of entries; must equal 2**(PTR_W-1).
PTR_W, 5, pointer width; the MSB is the wrap bit.
AF_LEVEL, 14, fifo_almost_full asserts when fill_level >= AF_LEVEL.
AE_LEVEL, 2, fifo_almost_empty asserts when fill_level <= AE_LEVEL.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_en  in  1  producer write request; data is on the array's data_in the same cycle.
rd_en  in  1  consumer read request; consumes the entry currently at rptr.
fifo_we  out  1  write strobe to the memory array (combinational).
wptr  out  PTR_W  write pointer to the array (registered).
rptr  out  PTR_W  read pointer to the array (registered).
fifo_full  out  1  FIFO holds DEPTH entries.
fifo_empty  out  1  FIFO holds 0 entries.
fifo_almost_full  out  1  fill_level >= AF_LEVEL.
fifo_almost_empty  out  1  fill_level <= AE_LEVEL.
fill_level  out  PTR_W  occupancy, range 0..DEPTH.
fifo_overflow  out  1  registered one-cycle pulse: a write was rejected.
fifo_underflow  out  1  registered one-cycle pulse: a read was rejected.

Behaviour:
- Reset (async assert, sync release):
  - wptr=0, rptr=0, fill_level=0.
  - fifo_empty=1, fifo_almost_empty=1, all other flags 0, fifo_we=0.
  - Reset asserted mid-operation discards contents immediately; the array is not cleared.
- Accepted write: wr_acc = wr_en & ~fifo_full, evaluated on current registered state.
  - fifo_we = wr_acc.
  - wptr <= wptr+1 at the next edge, modulo 2**PTR_W.
- Accepted read: rd_acc = rd_en & ~fifo_empty.
  - rptr <= rptr+1 at the next edge, modulo 2**PTR_W.
- Wrap-around: the pointers roll 31 -> 0. The array addresses with ptr[3:0]; the MSB toggles each lap.
- Flags are decoded combinationally from the registered pointers only, so they never depend on same-cycle wr_en/rd_en:
  - fifo_empty = (wptr == rptr).
  - fifo_full = (wptr[4] != rptr[4]) & (wptr[3:0] == rptr[3:0]).
  - fill_level = wptr - rptr, modulo 32.
- Flags update one cycle after the accepted operation (latency 1).
- Simultaneous rd_en and wr_en:
  - Neither full nor empty: both accepted, fill_level unchanged, both pointers advance.
  - Full: the read is accepted and the write is rejected (fifo_overflow pulses).
  - Empty: the write is accepted and the read is rejected (fifo_underflow pulses). Data is never bypassed.
- Error pulses:
  - fifo_overflow <= wr_en & fifo_full.
  - fifo_underflow <= rd_en & fifo_empty.
  - Each is high for exactly one cycle per offending request cycle. Rejected requests never move the pointers.
- There is no state machine. State is two pointer registers plus two error registers; all outputs derive from these.

Decomposition:
- Shared package fifo_pkg: DEPTH, PTR_W, AF_LEVEL/AE_LEVEL defaults, and a ptr_t typedef (logic [PTR_W-1:0]).
- One natural sub-module: fifo_ptr_cnt, a wrap-bit pointer register with increment enable. Instantiate it twice (write side, read side).
- The flag decode stays in the top block.

Test Plan:
- Reset then idle: rst_n low then high, no requests -> wptr=rptr=0, fifo_empty=1, fifo_almost_empty=1, fill_level=0, fifo_we=0.
- Fill to full: 16 consecutive wr_en cycles -> fifo_almost_full rises after the 14th write. After the 16th: fifo_full=1, fill_level=16, wptr=5'b10000. A 17th write gives fifo_we=0, fifo_overflow=1 for one cycle, wptr unchanged.
- Drain to empty: from full, 16 rd_en cycles -> rptr=5'b10000, fifo_empty=1. A 17th read gives fifo_underflow=1 for one cycle, rptr unchanged.
- Wrap-around: 40 interleaved write/read pairs -> both pointers pass 31 -> 0. fill_level stays constant. FWFT data matches a scoreboard through the array.
- Simultaneous at boundaries:
  - Full + rd_en + wr_en -> read accepted, overflow pulse, fill_level 15.
  - Empty + both -> write accepted, underflow pulse, fill_level 1.
- Async reset mid-stream: rst_n dropped at fill_level=9 between clock edges -> pointers and flags return to reset values immediately, without waiting for clk.
